// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types, constants and helpers for sync_fifo_pro
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Bit positions inside err_sticky
  localparam int ERR_OVF = 1;
  localparam int ERR_UNF = 0;

  // True when n is a positive power of two
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - DEPTH x DATA_WIDTH storage, sync write port, async read port
module fifo_mem_2p #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only accepted writes touch it
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_pro.sv
// rtl/sync_fifo_pro.sv - single-clock FIFO with FWFT option, count, thresholds and sticky errors
module sync_fifo_pro
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = $clog2(DEPTH),
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [PTR_WIDTH:0]    count,
  output logic [1:0]            err_sticky,
  input  logic                  clr_err
);

  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  // Thresholds and depth resized to the count width for clean comparisons
  localparam int          AF_INT  = AF_LEVEL;
  localparam int          AE_INT  = AE_LEVEL;
  localparam int          DEP_INT = DEPTH;
  localparam logic [PTR_WIDTH:0] DEPTH_C = DEP_INT[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AF_C    = AF_INT[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AE_C    = AE_INT[PTR_WIDTH:0];

  if (!is_pow2(DEPTH) || (DEPTH < 4)) begin : g_bad_depth
    $fatal(1, "sync_fifo_pro: DEPTH must be a power of two and at least 4");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $fatal(1, "sync_fifo_pro: AF_LEVEL must lie in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $fatal(1, "sync_fifo_pro: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [PTR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags are pure decodes of the registered count so they move with it
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign err_sticky   = err_q;

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  fifo_mem_2p #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_q[PTR_WIDTH-1:0]),
    .wdata (w_data),
    .raddr (rd_ptr_q[PTR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  // Next-state for pointers, occupancy, error pulses, sticky errors and read register
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_d       = err_q;
    data_d      = data_q;
    overflow_d  = wr_en && full;
    underflow_d = rd_en && empty;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      // Popped word: registered output in standard mode, hold value in FWFT mode
      data_d   = mem_rdata;
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new error in the same cycle as clr_err must survive the clear
    if (clr_err) begin
      err_d = 2'b00;
    end
    if (overflow_d) begin
      err_d[ERR_OVF] = 1'b1;
    end
    if (underflow_d) begin
      err_d[ERR_UNF] = 1'b1;
    end
  end

  // Control and data registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      err_q       <= 2'b00;
      data_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      err_q       <= err_d;
      data_q      <= data_d;
    end
  end

  // FWFT shows the head word live; while empty it falls back to the last popped word
  always_comb begin
    r_data = data_q;
    if ((MODE == FIFO_FWFT) && !empty) begin
      r_data = mem_rdata;
    end
  end

endmodule
